// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS controller: state codes, mux
// encodings, ALU control codes and opcode/funct values.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11,
    S_JAL    = 4'd12,
    S_JR     = 4'd13
  } state_e;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_RS     = 2'b11;

  localparam logic [4:0] ALU_AND  = 5'b00000;
  localparam logic [4:0] ALU_OR   = 5'b00001;
  localparam logic [4:0] ALU_ADD  = 5'b00010;
  localparam logic [4:0] ALU_SUB  = 5'b00110;
  localparam logic [4:0] ALU_SLT  = 5'b00111;
  localparam logic [4:0] ALU_SLTU = 5'b10111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_NOP  = 6'b000000;
  localparam logic [5:0] F_JR   = 6'b001000;
  localparam logic [5:0] F_ADD  = 6'b100000;
  localparam logic [5:0] F_ADDU = 6'b100001;
  localparam logic [5:0] F_SUB  = 6'b100010;
  localparam logic [5:0] F_SUBU = 6'b100011;
  localparam logic [5:0] F_AND  = 6'b100100;
  localparam logic [5:0] F_OR   = 6'b100101;
  localparam logic [5:0] F_SLT  = 6'b101010;
  localparam logic [5:0] F_SLTU = 6'b101011;

endpackage

// File: rtl/mc_aludec.sv
// R-type funct field to ALU control decode.
module mc_aludec
  import mips_pkg::*;
#(
  parameter int ALUCTL_W = 5
) (
  input  logic [5:0]          funct,
  output logic [ALUCTL_W-1:0] alucontrol
);

  always_comb begin
    case (funct)
      F_ADD, F_ADDU, F_NOP: alucontrol = ALUCTL_W'(ALU_ADD);
      F_SUB, F_SUBU:        alucontrol = ALUCTL_W'(ALU_SUB);
      F_AND:                alucontrol = ALUCTL_W'(ALU_AND);
      F_OR:                 alucontrol = ALUCTL_W'(ALU_OR);
      F_SLT:                alucontrol = ALUCTL_W'(ALU_SLT);
      F_SLTU:               alucontrol = ALUCTL_W'(ALU_SLTU);
      default:              alucontrol = ALUCTL_W'(ALU_AND);
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM with memory wait timeout and sticky
// memerr/illegal error flags.
module mc_controller
  import mips_pkg::*;
#(
  parameter int ALUCTL_W = 5,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          op,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pcen,
  output logic                iord,
  output logic                irwrite,
  output logic                memread,
  output logic                memwrite,
  output logic                regwrite,
  output logic                regdst,
  output logic                memtoreg,
  output logic                alusrca,
  output logic [1:0]          alusrcb,
  output logic [1:0]          pcsrc,
  output logic                signext,
  output logic                shiftl16,
  output logic                jal,
  output logic [ALUCTL_W-1:0] alucontrol,
  output logic                memerr,
  output logic                illegal,
  output logic [3:0]          state
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] TO_MAX  = 8'(TIMEOUT);

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  memerr_q, illegal_q;
  logic                  memerr_set, illegal_set;
  logic                  wait_st, timeout;
  logic [ALUCTL_W-1:0]   rtype_alu;

  mc_aludec #(.ALUCTL_W(ALUCTL_W)) u_aludec (
    .funct      (funct),
    .alucontrol (rtype_alu)
  );

  // The abort fires on the wait cycle that would bring the counter to TIMEOUT.
  assign wait_st = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
  assign timeout = wait_st && !mem_ready && (cnt_q >= TO_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      memerr_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      memerr_q  <= memerr_q | memerr_set;
      illegal_q <= illegal_q | illegal_set;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (timeout || (state_d != state_q))
      cnt_d = '0;
    else if (wait_st && !mem_ready && (cnt_q != TO_MAX))
      cnt_d = cnt_q + 8'd1;
  end

  always_comb begin
    state_d     = state_q;
    memerr_set  = 1'b0;
    illegal_set = 1'b0;
    pcen        = 1'b0;
    iord        = 1'b0;
    irwrite     = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    regwrite    = 1'b0;
    regdst      = 1'b0;
    memtoreg    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = SRCB_RT;
    pcsrc       = PCSRC_ALU;
    signext     = 1'b0;
    shiftl16    = 1'b0;
    jal         = 1'b0;
    alucontrol  = ALUCTL_W'(ALU_ADD);

    case (state_q)
      S_FETCH: begin
        memread = 1'b1;
        alusrcb = SRCB_FOUR;
        if (mem_ready) begin
          irwrite = 1'b1;
          pcen    = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          memerr_set = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_DECODE: begin
        alusrcb = SRCB_IMMSH2;
        signext = 1'b1;
        case (op)
          OP_LW, OP_SW:                                 state_d = S_MEMADR;
          OP_RTYPE:  state_d = (funct == F_JR) ? S_JR : S_REXEC;
          OP_BEQ, OP_BNE:                               state_d = S_BRANCH;
          OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI, OP_SLTI:   state_d = S_IEXEC;
          OP_J:                                         state_d = S_JUMP;
          OP_JAL:                                       state_d = S_JAL;
          default: begin
            illegal_set = 1'b1;
            state_d     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        signext = 1'b1;
        state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        memread = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
        else if (timeout) begin
          memerr_set = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWR: begin
        iord     = 1'b1;
        memwrite = !timeout;
        if (mem_ready) state_d = S_FETCH;
        else if (timeout) begin
          memerr_set = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_REXEC: begin
        alusrca    = 1'b1;
        alucontrol = rtype_alu;
        state_d    = S_RWB;
      end
      S_RWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALUCTL_W'(ALU_SUB);
        pcsrc      = PCSRC_ALUOUT;
        pcen       = (op == OP_BEQ) ? zero : !zero;
        state_d    = S_FETCH;
      end
      S_IEXEC: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        case (op)
          OP_ORI:  alucontrol = ALUCTL_W'(ALU_OR);
          OP_LUI:  shiftl16 = 1'b1;
          OP_SLTI: begin
            signext    = 1'b1;
            alucontrol = ALUCTL_W'(ALU_SLT);
          end
          default: signext = 1'b1;
        endcase
        state_d = S_IWB;
      end
      S_IWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pcen    = 1'b1;
        pcsrc   = PCSRC_JUMP;
        state_d = S_FETCH;
      end
      S_JAL: begin
        regwrite = 1'b1;
        jal      = 1'b1;
        pcen     = 1'b1;
        pcsrc    = PCSRC_JUMP;
        state_d  = S_FETCH;
      end
      S_JR: begin
        pcen    = 1'b1;
        pcsrc   = PCSRC_RS;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset is asynchronous, so keep every side effect quiet while it is held.
    if (reset) begin
      pcen     = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
    end
  end

  assign memerr  = memerr_q;
  assign illegal = illegal_q;
  assign state   = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench: each instruction is expanded into its expected state path
// and per-state control values, then compared cycle by cycle.
module tb_mc_controller;

  localparam int TO = 4;

  localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001, OP_SLTI = 6'b001010, OP_ORI = 6'b001101;
  localparam logic [5:0] OP_LUI = 6'b001111, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] FN_JR = 6'b001000;
  localparam logic [4:0] A_AND = 5'b00000, A_OR = 5'b00001, A_ADD = 5'b00010;
  localparam logic [4:0] A_SUB = 5'b00110, A_SLT = 5'b00111, A_SLTU = 5'b10111;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       pcen, iord, irwrite, memread, memwrite, regwrite, regdst, memtoreg;
  logic       alusrca, signext, shiftl16, jal, memerr, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [4:0] alucontrol;
  logic [3:0] state;

  mc_controller #(.ALUCTL_W(5), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pcen(pcen), .iord(iord), .irwrite(irwrite),
    .memread(memread), .memwrite(memwrite), .regwrite(regwrite),
    .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .signext(signext),
    .shiftl16(shiftl16), .jal(jal), .alucontrol(alucontrol),
    .memerr(memerr), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   failures = 0;
  int   ncyc;
  logic exp_memerr, exp_illegal;

  // Bit layout: 20 pcen,19 iord,18 irwrite,17 memread,16 memwrite,15 regwrite,
  // 14 regdst,13 memtoreg,12 alusrca,11:10 alusrcb,9:8 pcsrc,7 signext,
  // 6 shiftl16,5 jal,4:0 alucontrol
  wire [20:0] obs_v = {pcen, iord, irwrite, memread, memwrite, regwrite, regdst,
                       memtoreg, alusrca, alusrcb, pcsrc, signext, shiftl16, jal,
                       alucontrol};
  localparam logic [20:0] M_EN = 21'h1D8000;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [4:0] ref_alu(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100001, 6'b000000: return A_ADD;
      6'b100010, 6'b100011:            return A_SUB;
      6'b100100:                       return A_AND;
      6'b100101:                       return A_OR;
      6'b101010:                       return A_SLT;
      6'b101011:                       return A_SLTU;
      default:                         return A_AND;
    endcase
  endfunction

  // One clock cycle expected in state st; entered and left on a falling edge.
  task automatic cyc(input int st, input logic rdy, input logic abrt, input logic ill);
    logic [20:0] ev, mv;
    ev = '0;
    mv = M_EN;
    mem_ready = rdy;
    #1;
    case (st)
      0: begin
        ev[17] = 1'b1; mv[19] = 1'b1;
        ev[11:10] = 2'b01; mv[12:10] = '1; ev[4:0] = A_ADD; mv[4:0] = '1;
        if (rdy) begin ev[20] = 1'b1; ev[18] = 1'b1; mv[9:8] = '1; end
      end
      1: begin ev[11:10] = 2'b11; mv[11:10] = '1; ev[7] = 1'b1; mv[7] = 1'b1; ev[4:0] = A_ADD; mv[4:0] = '1; end
      2: begin
        ev[12] = 1'b1; ev[11:10] = 2'b10; mv[12:10] = '1;
        ev[7] = 1'b1; mv[7] = 1'b1; ev[4:0] = A_ADD; mv[4:0] = '1;
      end
      3: begin ev[19] = 1'b1; mv[19] = 1'b1; ev[17] = 1'b1; end
      4: begin ev[15] = 1'b1; ev[13] = 1'b1; mv[14:13] = '1; mv[5] = 1'b1; end
      5: begin ev[19] = 1'b1; mv[19] = 1'b1; ev[16] = !abrt; end
      6: begin ev[12] = 1'b1; mv[12:10] = '1; ev[4:0] = ref_alu(funct); mv[4:0] = '1; end
      7: begin ev[15] = 1'b1; ev[14] = 1'b1; mv[14:13] = '1; mv[5] = 1'b1; end
      8: begin
        ev[12] = 1'b1; mv[12:10] = '1; ev[4:0] = A_SUB; mv[4:0] = '1;
        ev[9:8] = 2'b01; mv[9:8] = '1; ev[20] = (op == OP_BEQ) ? zero : !zero;
      end
      9: begin
        ev[12] = 1'b1; ev[11:10] = 2'b10; mv[12:10] = '1; mv[6] = 1'b1; mv[4:0] = '1;
        case (op)
          OP_ORI:  begin ev[4:0] = A_OR; mv[7] = 1'b1; end
          OP_LUI:  begin ev[4:0] = A_ADD; ev[6] = 1'b1; end
          OP_SLTI: begin ev[4:0] = A_SLT; ev[7] = 1'b1; mv[7] = 1'b1; end
          default: begin ev[4:0] = A_ADD; ev[7] = 1'b1; mv[7] = 1'b1; end
        endcase
      end
      10: begin ev[15] = 1'b1; mv[14:13] = '1; mv[5] = 1'b1; end
      11: begin ev[20] = 1'b1; ev[9:8] = 2'b10; mv[9:8] = '1; end
      12: begin ev[20] = 1'b1; ev[15] = 1'b1; ev[5] = 1'b1; ev[9:8] = 2'b10; mv[9:8] = '1; mv[5] = 1'b1; end
      default: begin ev[20] = 1'b1; ev[9:8] = 2'b11; mv[9:8] = '1; end
    endcase
    check_val("state", {28'd0, state}, st);
    check_val($sformatf("ctrl_s%0d", st), {11'd0, obs_v & mv}, {11'd0, ev & mv});
    check_val("memerr", {31'd0, memerr}, {31'd0, exp_memerr});
    check_val("illegal", {31'd0, illegal}, {31'd0, exp_illegal});
    ncyc++;
    @(posedge clk);
    if (abrt) exp_memerr = 1'b1;
    if (ill) exp_illegal = 1'b1;
    @(negedge clk);
  endtask

  // Memory wait: wn cycles without ready, aborting once TO cycles are used up.
  task automatic mem_wait(input int st, input int wn, output logic aborted);
    aborted = 1'b0;
    if (wn >= TO) begin
      for (int k = 0; k < TO; k++) cyc(st, 1'b0, k == TO - 1, 1'b0);
      aborted = 1'b1;
    end else begin
      for (int k = 0; k < wn; k++) cyc(st, 1'b0, 1'b0, 1'b0);
      cyc(st, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                           input int wf, input int wm);
    logic ab;
    op = o; funct = f; zero = z; ncyc = 0;
    mem_wait(0, wf, ab);
    if (!ab) begin
      case (o)
        OP_LW, OP_SW: begin
          cyc(1, 1'($urandom), 1'b0, 1'b0);
          cyc(2, 1'($urandom), 1'b0, 1'b0);
          mem_wait((o == OP_LW) ? 3 : 5, wm, ab);
          if (!ab && o == OP_LW) cyc(4, 1'($urandom), 1'b0, 1'b0);
        end
        OP_R: begin
          cyc(1, 1'($urandom), 1'b0, 1'b0);
          if (f == FN_JR) cyc(13, 1'($urandom), 1'b0, 1'b0);
          else begin cyc(6, 1'($urandom), 1'b0, 1'b0); cyc(7, 1'($urandom), 1'b0, 1'b0); end
        end
        OP_BEQ, OP_BNE: begin cyc(1, 1'b0, 1'b0, 1'b0); cyc(8, 1'($urandom), 1'b0, 1'b0); end
        OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI, OP_SLTI: begin
          cyc(1, 1'b0, 1'b0, 1'b0); cyc(9, 1'($urandom), 1'b0, 1'b0); cyc(10, 1'($urandom), 1'b0, 1'b0);
        end
        OP_J:   begin cyc(1, 1'b0, 1'b0, 1'b0); cyc(11, 1'($urandom), 1'b0, 1'b0); end
        OP_JAL: begin cyc(1, 1'b0, 1'b0, 1'b0); cyc(12, 1'($urandom), 1'b0, 1'b0); end
        default: cyc(1, 1'($urandom), 1'b0, 1'b1);
      endcase
    end
    $display("txn op=%b funct=%b zero=%0d wf=%0d wm=%0d cycles=%0d memerr=%0d illegal=%0d",
             o, f, z, wf, wm, ncyc, exp_memerr, exp_illegal);
  endtask

  function automatic bit legal_op(input logic [5:0] o);
    case (o)
      OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI,
      OP_ORI, OP_LUI, OP_LW, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic [5:0] fn_tab [10] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                              6'b100101, 6'b101010, 6'b101011, 6'b000000, 6'b000111};
  logic [5:0] op_tab [12] = '{OP_LW, OP_SW, OP_R, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU,
                              OP_ORI, OP_LUI, OP_SLTI, OP_J, OP_JAL};

  initial begin
    logic [5:0] ro, rf;
    int wf, wm;
    reset = 1'b1; mem_ready = 1'b0; op = '0; funct = '0; zero = 1'b0;
    exp_memerr = 1'b0; exp_illegal = 1'b0;
    repeat (2) @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check_val("rst_state", {28'd0, state}, 32'd0);
    check_val("rst_enables", {27'd0, pcen, irwrite, memwrite, regwrite, memerr | illegal}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run_instr(OP_LW, 6'd0, 1'b0, 0, 0);
    run_instr(OP_BEQ, 6'd0, 1'b1, 0, 0);
    run_instr(OP_BNE, 6'd0, 1'b1, 0, 0);
    run_instr(OP_SW, 6'd0, 1'b0, 0, 3);
    run_instr(OP_R, 6'b101010, 1'b0, 3, 0);
    run_instr(OP_ADDI, 6'd0, 1'b0, 4, 0);
    run_instr(OP_JAL, 6'd0, 1'b0, 0, 0);
    run_instr(OP_R, FN_JR, 1'b0, 0, 0);
    run_instr(6'b111111, 6'd0, 1'b0, 0, 0);

    for (int i = 0; i < 150; i++) begin
      wf = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 5);
      wm = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 2) : $urandom_range(3, 5);
      rf = fn_tab[$urandom_range(0, 9)];
      case ($urandom_range(0, 13))
        12: begin ro = OP_R; rf = FN_JR; end
        13: begin
          ro = 6'($urandom);
          while (legal_op(ro)) ro = 6'($urandom);
        end
        default: ro = op_tab[$urandom_range(0, 11)];
      endcase
      run_instr(ro, rf, 1'($urandom), wf, wm);
    end

    // Asynchronous reset in the middle of a load.
    if (!exp_illegal) run_instr(6'b111111, 6'd0, 1'b0, 0, 0);
    op = OP_LW; funct = '0; ncyc = 0;
    cyc(0, 1'b1, 1'b0, 1'b0);
    cyc(1, 1'b0, 1'b0, 1'b0);
    cyc(2, 1'b0, 1'b0, 1'b0);
    cyc(3, 1'b0, 1'b0, 1'b0);
    mem_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_val("async_rst_state", {28'd0, state}, 32'd0);
    check_val("async_rst_flags", {30'd0, memerr, illegal}, 32'd0);
    exp_memerr = 1'b0; exp_illegal = 1'b0;
    @(negedge clk);
    mem_ready = 1'b1;
    #1;
    check_val("rst_held_enables", {28'd0, pcen, irwrite, memwrite, regwrite}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_instr(OP_LW, 6'd0, 1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
